pipelined_main_decoder: RTL

- Parametrised successor to the combinational main decoder.
- Decodes the D-stage opcode into control fields, with an extended ISA option: BNE, ANDI, ORI, SLTI, LUI, JAL.
- Carries those fields through the E/M/W control pipeline registers, with stall/flush bubble insertion, illegal-opcode detection and a saturating illegal-opcode counter.
- Sits between instruction decode and the hazard unit / datapath stage registers.

---
 rtl/mips_ctrl_pkg.sv | 73 +++++++
 rtl/main_decode_lut.sv | 93 +++++++++
 rtl/pipelined_main_decoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control-field definitions for the MIPS main decoder
// and its E/M/W control pipeline.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  typedef struct packed {
    logic branch;
    logic bne;
    logic jump;
  } ctrl_d_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       link;
    logic       zeroext;
    logic [2:0] alu_op;
  } ctrl_e_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic link;
  } ctrl_m_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic link;
  } ctrl_w_t;

  function automatic ctrl_m_t to_m(input ctrl_e_t e);
    ctrl_m_t m;
    m.regwrite = e.regwrite;
    m.memtoreg = e.memtoreg;
    m.memwrite = e.memwrite;
    m.link     = e.link;
    return m;
  endfunction

  function automatic ctrl_w_t to_w(input ctrl_m_t m);
    ctrl_w_t w;
    w.regwrite = m.regwrite;
    w.memtoreg = m.memtoreg;
    w.link     = m.link;
    return w;
  endfunction

endpackage

// File: rtl/main_decode_lut.sv
// Combinational opcode decode table: opcode to control fields
// plus an unrecognised-opcode flag.
module main_decode_lut
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int EXT_ISA = 1
) (
  input  logic [OP_W-1:0] op,
  output ctrl_d_t         ctrl_d,
  output ctrl_e_t         ctrl_e,
  output logic            illegal
);

  logic       hi_bad;
  logic       ext;
  logic [6:0] key;

  assign hi_bad = |(op >> 6);
  assign ext    = (EXT_ISA != 0);
  // Upper opcode bits fold into the key so no table row can match.
  assign key    = {hi_bad, op[5:0]};

  always_comb begin
    ctrl_d  = '0;
    ctrl_e  = '0;
    illegal = 1'b0;
    unique case (1'b1)
      key == {1'b0, OP_RTYPE}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.regdst   = 1'b1;
        ctrl_e.alu_op   = ALU_FUNCT;
      end
      key == {1'b0, OP_LW}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.memtoreg = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.alu_op   = ALU_ADD;
      end
      key == {1'b0, OP_SW}: begin
        ctrl_e.memwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.alu_op   = ALU_ADD;
      end
      key == {1'b0, OP_BEQ}: begin
        ctrl_d.branch = 1'b1;
        ctrl_e.alu_op = ALU_SUB;
      end
      key == {1'b0, OP_ADDI}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.alu_op   = ALU_ADD;
      end
      key == {1'b0, OP_J}: begin
        ctrl_d.jump = 1'b1;
      end
      ext && key == {1'b0, OP_BNE}: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.bne    = 1'b1;
        ctrl_e.alu_op = ALU_SUB;
      end
      ext && key == {1'b0, OP_ANDI}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.zeroext  = 1'b1;
        ctrl_e.alu_op   = ALU_AND;
      end
      ext && key == {1'b0, OP_ORI}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.zeroext  = 1'b1;
        ctrl_e.alu_op   = ALU_OR;
      end
      ext && key == {1'b0, OP_SLTI}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.alu_op   = ALU_SLT;
      end
      ext && key == {1'b0, OP_LUI}: begin
        ctrl_e.regwrite = 1'b1;
        ctrl_e.alusrc   = 1'b1;
        ctrl_e.alu_op   = ALU_LUI;
      end
      ext && key == {1'b0, OP_JAL}: begin
        ctrl_d.jump     = 1'b1;
        ctrl_e.regwrite = 1'b1;
        ctrl_e.link     = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_main_decoder.sv
// Main decoder with E/M/W control pipeline, bubble insertion
// and a saturating illegal-opcode counter.
module pipelined_main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W      = 7,
  parameter int ALU_OP_W  = 3,
  parameter int EXT_ISA   = 1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      op_d,
  input  logic                 valid_d,
  input  logic                 stall_d,
  input  logic                 flush_e,
  output logic                 branch_d,
  output logic                 bne_d,
  output logic                 jump_d,
  output logic                 illegal_d,
  output logic                 regwrite_e,
  output logic                 memtoreg_e,
  output logic                 memwrite_e,
  output logic                 alusrc_e,
  output logic                 regdst_e,
  output logic                 link_e,
  output logic                 zeroext_e,
  output logic [ALU_OP_W-1:0]  alu_op_e,
  output logic                 regwrite_m,
  output logic                 memtoreg_m,
  output logic                 memwrite_m,
  output logic                 link_m,
  output logic                 regwrite_w,
  output logic                 memtoreg_w,
  output logic                 link_w,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  localparam logic [ILL_CNT_W-1:0] CNT_ONE = 1;

  ctrl_d_t dec_d;
  ctrl_e_t dec_e;
  logic    dec_ill;

  ctrl_e_t e_q;
  ctrl_m_t m_q;
  ctrl_w_t w_q;
  logic [ILL_CNT_W-1:0] cnt_q;

  logic go;
  logic issue;
  logic count_ill;

  main_decode_lut #(
    .OP_W    (OP_W),
    .EXT_ISA (EXT_ISA)
  ) u_lut (
    .op      (op_d),
    .ctrl_d  (dec_d),
    .ctrl_e  (dec_e),
    .illegal (dec_ill)
  );

  assign branch_d  = valid_d & dec_d.branch;
  assign bne_d     = valid_d & dec_d.bne;
  assign jump_d    = valid_d & dec_d.jump;
  assign illegal_d = valid_d & dec_ill;

  // A stalled or flushed slot never issues, so E sees a bubble.
  assign go        = valid_d & ~stall_d & ~flush_e;
  assign issue     = go & ~dec_ill;
  assign count_ill = go & dec_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= issue ? dec_e : '0;
      m_q <= to_m(e_q);
      w_q <= to_w(m_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (count_ill && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign regwrite_e  = e_q.regwrite;
  assign memtoreg_e  = e_q.memtoreg;
  assign memwrite_e  = e_q.memwrite;
  assign alusrc_e    = e_q.alusrc;
  assign regdst_e    = e_q.regdst;
  assign link_e      = e_q.link;
  assign zeroext_e   = e_q.zeroext;
  assign alu_op_e    = ALU_OP_W'(e_q.alu_op);

  assign regwrite_m  = m_q.regwrite;
  assign memtoreg_m  = m_q.memtoreg;
  assign memwrite_m  = m_q.memwrite;
  assign link_m      = m_q.link;

  assign regwrite_w  = w_q.regwrite;
  assign memtoreg_w  = w_q.memtoreg;
  assign link_w      = w_q.link;

  assign illegal_cnt = cnt_q;

endmodule
